// File: rtl/size_cfg_bank.sv
// rtl/size_cfg_bank.sv - shadowed per-channel length registers with a busy-gated commit to the active set
module size_cfg_bank #(
    parameter int NCH      = 2,
    parameter int DW       = 5,
    parameter int MIN_SIZE = 1,
    parameter int MAX_SIZE = 2**DW-1,
    localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              err_clr,
    input  logic              wr_en,
    input  logic [SW-1:0]     wr_sel,
    input  logic [DW-1:0]     wr_data,
    input  logic              commit_req,
    input  logic              core_busy,
    output logic              commit_ack,
    output logic [NCH*DW-1:0] size_o,
    output logic              pending_o,
    output logic [NCH-1:0]    err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, COPY} state_t;

    localparam logic [DW-1:0] MIN_V = DW'(MIN_SIZE);
    localparam logic [DW-1:0] MAX_V = DW'(MAX_SIZE);

    state_t        state;
    logic [DW-1:0] shadow [NCH];
    logic [DW-1:0] active [NCH];
    logic          wr_ok;
    logic          wr_lo;
    logic          wr_hi;
    logic [DW-1:0] wr_val;

    // Writes to channels beyond NCH are dropped entirely.
    always_comb begin
        wr_ok  = wr_en && (32'(wr_sel) < NCH);
        wr_lo  = int'({1'b0, wr_data}) < MIN_SIZE;
        wr_hi  = int'({1'b0, wr_data}) > MAX_SIZE;
        wr_val = wr_data;
        if (wr_lo) begin
            wr_val = MIN_V;
        end else if (wr_hi) begin
            wr_val = MAX_V;
        end
    end

    always_comb begin
        size_o = '0;
        for (int k = 0; k < NCH; k++) begin
            size_o[k*DW +: DW] = active[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= IDLE;
            commit_ack <= 1'b0;
            pending_o  <= 1'b0;
            err_o      <= '0;
            for (int k = 0; k < NCH; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            commit_ack <= 1'b0;
            if (err_clr) begin
                err_o <= '0;
            end
            // Later assignments win, so a clamping write beats err_clr.
            if (wr_ok) begin
                shadow[wr_sel] <= wr_val;
                pending_o      <= 1'b1;
                if (wr_lo || wr_hi) begin
                    err_o[wr_sel] <= 1'b1;
                end
            end
            case (state)
                IDLE: if (commit_req) state <= WAIT;
                WAIT: if (!core_busy) state <= COPY;
                COPY: begin
                    // Copies the pre-edge shadow; a same-cycle write stays pending.
                    for (int k = 0; k < NCH; k++) begin
                        active[k] <= shadow[k];
                    end
                    commit_ack <= 1'b1;
                    if (!wr_ok) begin
                        pending_o <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_size_cfg_bank.sv
// tb/tb_size_cfg_bank.sv - directed self-checking bench for size_cfg_bank
module tb_size_cfg_bank;

    logic        clk = 1'b0;
    logic        rst, clr, err_clr, wr_en, commit_req, core_busy;
    logic [0:0]  wr_sel;
    logic [4:0]  wr_data;
    logic        commit_ack, pending_o;
    logic [9:0]  size_o;
    logic [1:0]  err_o;

    logic        clr3, err_clr3, wr_en3, commit_req3, core_busy3;
    logic [1:0]  wr_sel3;
    logic [4:0]  wr_data3;
    logic        commit_ack3, pending3;
    logic [14:0] size3;
    logic [2:0]  err3;

    int n_checks = 0;
    int n_fail   = 0;
    int acks;

    always #5 clk = ~clk;

    size_cfg_bank dut (
        .clk(clk), .rst(rst), .clr(clr), .err_clr(err_clr), .wr_en(wr_en),
        .wr_sel(wr_sel), .wr_data(wr_data), .commit_req(commit_req),
        .core_busy(core_busy), .commit_ack(commit_ack), .size_o(size_o),
        .pending_o(pending_o), .err_o(err_o)
    );

    size_cfg_bank #(.NCH(3)) dut3 (
        .clk(clk), .rst(rst), .clr(clr3), .err_clr(err_clr3), .wr_en(wr_en3),
        .wr_sel(wr_sel3), .wr_data(wr_data3), .commit_req(commit_req3),
        .core_busy(core_busy3), .commit_ack(commit_ack3), .size_o(size3),
        .pending_o(pending3), .err_o(err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel[0:0];
        wr_data = data[4:0];
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic commit_wait(input string tag);
        int lat;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        lat = 0;
        while (!commit_ack && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clr = 1'b0; err_clr = 1'b0; wr_en = 1'b0; wr_sel = '0;
        wr_data = '0; commit_req = 1'b0; core_busy = 1'b0;
        clr3 = 1'b0; err_clr3 = 1'b0; wr_en3 = 1'b0; wr_sel3 = '0;
        wr_data3 = '0; commit_req3 = 1'b0; core_busy3 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_size", size_o, 0);
        check("rst_err", err_o, 0);
        check("rst_pend", pending_o, 0);
        check("rst_ack", commit_ack, 0);

        // basic write + commit, edge-by-edge latency
        wr(1, 12);
        check("a_pend_set", pending_o, 1);
        check("a_size_hold", size_o, 0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("a_ack_t0", commit_ack, 0);
        tick();
        check("a_ack_t1", commit_ack, 0);
        check("a_size_t1", size_o, 0);
        tick();
        check("a_ack_t2", commit_ack, 1);
        check("a_ch1", size_o[9:5], 12);
        check("a_pend_clr", pending_o, 0);
        tick();
        check("a_ack_pulse", commit_ack, 0);

        // clamping and sticky error flags
        wr(0, 0);
        check("b_err_set", err_o, 2'b01);
        commit_wait("b_commit");
        check("b_size", size_o, (12 << 5) | 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("b_err_clr", err_o, 0);
        err_clr = 1'b1;
        wr(0, 0);
        err_clr = 1'b0;
        check("b_err_prio", err_o, 2'b01);

        // commit held off by core_busy
        wr(0, 3);
        commit_req = 1'b1;
        core_busy  = 1'b1;
        tick();
        commit_req = 1'b0;
        acks = 0;
        repeat (10) begin
            tick();
            if (commit_ack) acks++;
        end
        check("c_no_ack", acks, 0);
        check("c_size_hold", size_o, (12 << 5) | 1);
        core_busy = 1'b0;
        tick();
        check("c_ack_early", commit_ack, 0);
        tick();
        check("c_ack", commit_ack, 1);
        check("c_size", size_o, (12 << 5) | 3);

        // write during COPY lands in shadow only
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        wr(0, 7);
        check("d_ack", commit_ack, 1);
        check("d_size_old", size_o, (12 << 5) | 3);
        check("d_pend", pending_o, 1);
        commit_wait("d_commit");
        check("d_size_new", size_o, (12 << 5) | 7);

        // rst during COPY aborts
        wr(1, 5);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("e_ack", commit_ack, 0);
        check("e_size", size_o, 0);

        // clr during WAIT, with a competing write
        wr(0, 4);
        commit_req = 1'b1;
        core_busy  = 1'b1;
        tick();
        commit_req = 1'b0;
        clr     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 5'd9;
        wr_sel  = 1'b0;
        tick();
        clr   = 1'b0;
        wr_en = 1'b0;
        core_busy = 1'b0;
        check("f_size", size_o, 0);
        check("f_pend", pending_o, 0);
        acks = 0;
        repeat (5) begin
            tick();
            if (commit_ack) acks++;
        end
        check("f_no_ack", acks, 0);
        commit_wait("f_commit");
        check("f_size_unconf", size_o, 0);

        // NCH=3: out-of-range select and duplicate commit_req
        wr_en3   = 1'b1;
        wr_sel3  = 2'd3;
        wr_data3 = 5'd0;
        tick();
        check("g_pend_ignore", pending3, 0);
        check("g_err_ignore", err3, 0);
        wr_sel3  = 2'd2;
        wr_data3 = 5'd20;
        tick();
        wr_en3 = 1'b0;
        check("g_pend", pending3, 1);
        commit_req3 = 1'b1;
        core_busy3  = 1'b1;
        tick();
        commit_req3 = 1'b0;
        tick();
        commit_req3 = 1'b1;
        tick();
        commit_req3 = 1'b0;
        core_busy3  = 1'b0;
        acks = 0;
        repeat (8) begin
            tick();
            if (commit_ack3) acks++;
        end
        check("g_one_ack", acks, 1);
        check("g_size", size3, 20 << 10);
        check("g_pend_clr", pending3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
